// File: rtl/spi_xfer_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared types and defaults for the SPI transfer arbiter slice.
//   spi_xfer_state_e : sequencer states (idle, CS setup, TX fetch,
//                      shift, CS hold)
//   SpiDefault*      : default parameter values for the arbiter
//   idx_width()      : index width for an N-entry selection, never below 1
// ---------------------------------------------------------------------------
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_SHIFT,
        ST_HOLD
    } spi_xfer_state_e;

    localparam int SpiDefaultNumCs    = 2;
    localparam int SpiDefaultLenWidth = 8;
    localparam int SpiDefaultCsSetup  = 2;
    localparam int SpiDefaultCsHold   = 2;

    // A one-entry selection still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_xfer_if
// Bundle of the requester command/data handshakes and the shift-engine
// handshake around spi_xfer_arbiter.
//   slave  : the arbiter's view (takes commands, TX bytes, engine results;
//            drives grants, RX strobes, engine start, chip selects, status)
//   master : the surrounding front end / engine view (the reverse)
// ---------------------------------------------------------------------------
interface spi_xfer_if
    import spi_ctrl_pkg::*;
#(
    parameter int NumReq   = 2,
    parameter int NumCs    = SpiDefaultNumCs,
    parameter int LenWidth = SpiDefaultLenWidth
);
    localparam int OwnerW = idx_width(NumReq);
    localparam int CsIdxW = idx_width(NumCs);

    logic [NumReq-1:0]          req_valid_i;
    logic [NumReq*LenWidth-1:0] req_len_i;
    logic [NumReq*CsIdxW-1:0]   req_cs_i;
    logic [NumReq-1:0]          req_ready_o;
    logic [NumReq-1:0]          tx_valid_i;
    logic [NumReq*8-1:0]        tx_data_i;
    logic [NumReq-1:0]          tx_ready_o;
    logic [NumReq-1:0]          rx_valid_o;
    logic [7:0]                 rx_data_o;
    logic                       eng_start_o;
    logic [7:0]                 eng_data_o;
    logic                       eng_done_i;
    logic [7:0]                 eng_rdata_i;
    logic [NumCs-1:0]           cs_no_o;
    logic                       busy_o;
    logic [OwnerW-1:0]          owner_o;

    modport slave (
        input  req_valid_i, req_len_i, req_cs_i, tx_valid_i, tx_data_i,
               eng_done_i, eng_rdata_i,
        output req_ready_o, tx_ready_o, rx_valid_o, rx_data_o,
               eng_start_o, eng_data_o, cs_no_o, busy_o, owner_o
    );

    modport master (
        output req_valid_i, req_len_i, req_cs_i, tx_valid_i, tx_data_i,
               eng_done_i, eng_rdata_i,
        input  req_ready_o, tx_ready_o, rx_valid_o, rx_data_o,
               eng_start_o, eng_data_o, cs_no_o, busy_o, owner_o
    );

endinterface

// File: rtl/spi_xfer_arbiter_rr.sv
// ---------------------------------------------------------------------------
// spi_rr_arbiter
// Round-robin grant over a request vector.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req           : request vector
//   update_en     : advance the pointer past the current grant
//   grant         : one-hot grant (combinational)
//   grant_idx     : index of the granted requester
//   grant_any     : some request is being granted
// ---------------------------------------------------------------------------
module spi_rr_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter  int NumReq = 2,
    localparam int IdxW   = idx_width(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req,
    input  logic              update_en,
    output logic [NumReq-1:0] grant,
    output logic [IdxW-1:0]   grant_idx,
    output logic              grant_any
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] cand [NumReq];

    // Scan requesters starting at the pointer and take the first one set.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            cand[i] = IdxW'((int'(ptr_q) + i) % NumReq);
            if (!grant_any && req[cand[i]]) begin
                grant_any = 1'b1;
                grant_idx = cand[i];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (update_en) begin
            ptr_q <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// spi_xfer_arbiter
// Shares one byte-level SPI shift engine among NumReq requesters. Commands
// are granted round-robin; the owner's chip select is framed with setup and
// hold spacing, TX bytes are fed to the engine one at a time and each
// received byte is strobed back to the owner.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : spi_xfer_if.slave (command, TX, RX, engine, CS, status)
// ---------------------------------------------------------------------------
module spi_xfer_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int NumCs         = SpiDefaultNumCs,
    parameter int LenWidth      = SpiDefaultLenWidth,
    parameter int CsSetupCycles = SpiDefaultCsSetup,
    parameter int CsHoldCycles  = SpiDefaultCsHold
) (
    input logic       clk_i,
    input logic       rst_ni,
    spi_xfer_if.slave bus
);

    localparam int OwnerW   = idx_width(NumReq);
    localparam int CsIdxW   = idx_width(NumCs);
    localparam int MaxSpace = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles : CsHoldCycles;
    localparam int CntW     = $clog2(MaxSpace + 1);

    spi_xfer_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [LenWidth-1:0] len_q;
    logic [CsIdxW-1:0]   cs_q;
    logic [OwnerW-1:0]   owner_q;
    logic [7:0]          eng_data_q;
    logic [7:0]          rx_data_q;
    logic                eng_start_q;
    logic [NumReq-1:0]   rx_valid_q;

    logic [NumReq-1:0]   grant;
    logic [OwnerW-1:0]   grant_idx;
    logic                grant_any;
    logic                grant_en, tx_fire, done_fire, busy;

    logic [LenWidth-1:0] req_len [NumReq];
    logic [CsIdxW-1:0]   req_cs  [NumReq];
    logic [7:0]          tx_byte [NumReq];
    logic [NumReq-1:0]   tx_ready;
    logic [NumCs-1:0]    cs_n;

    // Per-requester views of the packed command and TX buses.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            req_len[i] = bus.req_len_i[i*LenWidth +: LenWidth];
            req_cs[i]  = bus.req_cs_i[i*CsIdxW +: CsIdxW];
            tx_byte[i] = bus.tx_data_i[i*8 +: 8];
        end
    end

    spi_rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (bus.req_valid_i),
        .update_en (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign busy      = (state_q != ST_IDLE);
    assign grant_en  = (state_q == ST_IDLE) && grant_any;
    assign tx_fire   = (state_q == ST_FETCH) && bus.tx_valid_i[owner_q];
    assign done_fire = (state_q == ST_SHIFT) && bus.eng_done_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Setup and hold share one spacing counter; it is cleared whenever a
    // spacing phase ends, so it always enters SETUP or HOLD at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CntW'(CsSetupCycles - 1)) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_FETCH: begin
                if (bus.tx_valid_i[owner_q]) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.eng_done_i) begin
                    state_d = (len_q == '0) ? ST_HOLD : ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CntW'(CsHoldCycles - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Command latch, byte registers and the one-cycle start/RX strobes.
    // The remaining-byte count stops at zero rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q       <= '0;
            cs_q        <= '0;
            owner_q     <= '0;
            eng_data_q  <= '0;
            rx_data_q   <= '0;
            eng_start_q <= 1'b0;
            rx_valid_q  <= '0;
        end else begin
            eng_start_q <= tx_fire;
            rx_valid_q  <= '0;
            if (grant_en) begin
                len_q   <= req_len[grant_idx];
                cs_q    <= req_cs[grant_idx];
                owner_q <= grant_idx;
            end
            if (tx_fire) begin
                eng_data_q <= tx_byte[owner_q];
            end
            if (done_fire) begin
                rx_data_q           <= bus.eng_rdata_i;
                rx_valid_q[owner_q] <= 1'b1;
                if (len_q != '0) begin
                    len_q <= len_q - LenWidth'(1);
                end
            end
        end
    end

    // Only the owner sees tx_ready; an out-of-range CS index matches no line.
    always_comb begin
        tx_ready = '0;
        if (state_q == ST_FETCH) begin
            tx_ready[owner_q] = 1'b1;
        end
        cs_n = '1;
        for (int i = 0; i < NumCs; i++) begin
            cs_n[i] = ~(busy && (cs_q == CsIdxW'(i)));
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE) ? grant : '0;
    assign bus.tx_ready_o  = tx_ready;
    assign bus.rx_valid_o  = rx_valid_q;
    assign bus.rx_data_o   = rx_data_q;
    assign bus.eng_start_o = eng_start_q;
    assign bus.eng_data_o  = eng_data_q;
    assign bus.cs_no_o     = cs_n;
    assign bus.busy_o      = busy;
    assign bus.owner_o     = owner_q;

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Transaction sequencer and arbiter that shares one byte-level SPI shift engine among `NumReq` requesters (for example the CPU MMIO path and a boot loader). It accepts per-requester transfer commands (byte count and chip-select index) and grants them round-robin. For the granted requester it drives chip-select with setup and hold spacing, moves TX bytes from that requester into the engine one at a time, and returns each received byte. It sits between the SPI MMIO/FIFO front end and the shift engine, inside the SPI top level.

## Interface
- `NumReq`, default 2: number of requesters, 2..4.
- `NumCs`, default 2: number of active-low chip-select outputs.
- `LenWidth`, default 8: command length width; the length field encodes bytes-1.
- `CsSetupCycles`, default 2: clk_i cycles between CS assertion and the first `eng_start_o`; must be ≥1.
- `CsHoldCycles`, default 2: clk_i cycles between the last `eng_done_i` and CS deassertion; must be ≥1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NumReq  command valid, one bit per requester.
- `req_len_i`  in  NumReq*LenWidth  bytes-1 per requester.
- `req_cs_i`  in  NumReq*$clog2(NumCs)  chip-select index per requester.
- `req_ready_o`  out  NumReq  command accepted, one-hot.
- `tx_valid_i`  in  NumReq  TX byte valid.
- `tx_data_i`  in  NumReq*8  TX byte.
- `tx_ready_o`  out  NumReq  TX byte consumed; only the owner's bit can be set.
- `rx_valid_o`  out  NumReq  one-cycle RX byte strobe to the owner; there is no backpressure.
- `rx_data_o`  out  8  RX byte, valid while `rx_valid_o` is non-zero.
- `eng_start_o`  out  1  one-cycle start pulse to the shift engine.
- `eng_data_o`  out  8  byte to shift; stable from `eng_start_o` until `eng_done_i`.
- `eng_done_i`  in  1  one-cycle pulse that ends a byte.
- `eng_rdata_i`  in  8  received byte, valid with `eng_done_i`.
- `cs_no_o`  out  NumCs  chip selects, active-low.
- `busy_o`  out  1  high in every state except IDLE.
- `owner_o`  out  $clog2(NumReq)  index of the current or last granted requester.

## Operation
- **States:** IDLE, SETUP, FETCH, SHIFT, HOLD.
- **IDLE:**
  - If any `req_valid_i` bit is set, grant the first set bit at or after the round-robin pointer.
  - `req_ready_o[g]` is combinational and is set in this same cycle.
  - Latch len, cs and owner. Set the pointer to g+1 modulo NumReq. Go to SETUP.
- **SETUP:** Assert `cs_no_o[cs]` low and count `CsSetupCycles`, then go to FETCH.
- **FETCH:**
  - `tx_ready_o[owner]` = 1, combinational.
  - On `tx_valid_i[owner]`, register the byte into `eng_data_o`, pulse `eng_start_o` on the next cycle, and go to SHIFT.
  - The arbiter waits in FETCH indefinitely; there is no timeout.
- **SHIFT:**
  - On `eng_done_i`, register `eng_rdata_i` to `rx_data_o` and pulse `rx_valid_o[owner]` on the next cycle.
  - If the remaining count is 0, go to HOLD. Otherwise decrement the count and go to FETCH.
- **HOLD:** Keep CS asserted for `CsHoldCycles`, then deassert it and go to IDLE.
  - IDLE always lasts at least 1 cycle, so CS stays high for ≥1 cycle between transactions, even back-to-back.
- **Ignored inputs:**
  - `eng_done_i` outside SHIFT.
  - Requests from non-owners while a transaction is active; those requesters keep `req_valid_i` asserted and wait.
  - `tx_valid_i` from non-owners.
- **Out-of-range CS:** if cs index ≥ NumCs, all CS lines stay high and the transfer still runs to completion.
- **Length arithmetic:** the length counter is LenWidth bits. len = 2^LenWidth-1 transfers 2^LenWidth bytes; the counter never wraps past 0.

## Timing
- **Reset values:**
  - `cs_no_o` all 1.
  - `req_ready_o`, `tx_ready_o`, `rx_valid_o`, `eng_start_o`, `busy_o` all 0.
  - `eng_data_o`, `rx_data_o`, `owner_o` all 0.
  - Round-robin pointer 0, state IDLE.
- **Latencies:**
  - Grant at cycle T: CS falls at T+1.
  - First `tx_ready_o` at T+1+CsSetupCycles.
  - TX handshake at cycle F: `eng_start_o` at F+1.
  - `eng_done_i` at D: `rx_valid_o` at D+1. If bytes remain, `tx_ready_o` is high again at D+1.
  - Last `eng_done_i` at D: CS rises at D+1+CsHoldCycles.
- **Reset mid-transaction:** CS deasserts asynchronously on `rst_ni` falling. No `rx_valid_o` is produced for the byte in flight. The shift engine must be reset by the same `rst_ni`.

## Structure
- **Package `spi_ctrl_pkg`:**
  - State enum `spi_xfer_state_e`.
  - Default parameter constants: `SpiDefaultNumCs`, `SpiDefaultLenWidth`, `SpiDefaultCsSetup`, `SpiDefaultCsHold`.
- **Sub-module `spi_rr_arbiter`:**
  - Combinational grant from a request vector and the pointer.
  - Pointer register with an update-enable input.
  - Reusable for future SPI sharing.
- **FSM, counters and data registers** stay in `spi_xfer_arbiter`.

## Test plan
- **Single transfer:** Req0 with len=2, cs=1, TX bytes A5,3C,FF; engine loops back each byte.
  - `cs_no_o` = 2'b01 for the whole transfer.
  - Three `eng_start_o` pulses.
  - RX bytes A5,3C,FF on `rx_valid_o[0]`.
  - CS rises exactly CsHoldCycles+1 cycles after the third `eng_done_i`.
- **Contention:** Req0 and Req1 both held valid continuously.
  - Grants alternate 0,1,0,1.
  - CS is high for ≥1 cycle between transactions.
  - `owner_o` tracks each grant.
- **TX stall:** owner withholds `tx_valid_i` for 20 cycles mid-transfer.
  - Stays in FETCH with CS held low and no `eng_start_o`.
  - Resumes with a start pulse one cycle after valid.
- **Spurious inputs:**
  - `eng_done_i` pulsed in IDLE and SETUP produces no `rx_valid_o`.
  - Req1 `tx_valid_i` while Req0 owns the transfer is never acknowledged.
- **Mid-transfer reset:** assert `rst_ni` low during SHIFT.
  - `cs_no_o` goes to all 1 immediately and all strobes go to 0.
  - After release, a new len=0 command completes normally with the grant going to req0.
- **Boundaries:**
  - len=0 transfers exactly 1 byte.
  - cs=NumCs keeps all CS high and still returns the RX byte.
  - len=8'hFF transfers 256 bytes.
